// File: rtl/div_clk_meter.sv
// div_clk_meter: measures the period and high time of a divided clock in
// clk_in cycles. It flags loss of signal and asserts a lock indicator once
// the period is stable.
// Optional feature macro: EXPECT_CHECK_EN. When it is defined, the design adds
// the period_ok output, which compares each measurement against DIV_NUM.
module div_clk_meter #(
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned LOCK_NUM = 4,
  parameter int unsigned DIV_NUM  = 8
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             locked,
  output logic             err_timeout
`ifdef EXPECT_CHECK_EN
  ,
  output logic             period_ok
`endif
);

  localparam int unsigned      LCK_W    = $clog2(LOCK_NUM + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [LCK_W-1:0] LOCK_TGT = LCK_W'(LOCK_NUM);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } state_e;

  // sync_q[0..1] form the synchronizer; sync_q[2] is the edge-detect delay
  logic [2:0]       sync_q, sync_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hi_cap_q, hi_cap_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_time_q, high_time_d;
  logic             meas_valid_q, meas_valid_d;
  logic             locked_q, locked_d;
  logic             err_timeout_q, err_timeout_d;
  logic [LCK_W-1:0] lock_cnt_q, lock_cnt_d;
  state_e           state_q, state_d;

  logic rise_c, fall_c, sat_c, publish_c, timeout_c;

`ifdef EXPECT_CHECK_EN
  logic period_ok_q, period_ok_d;
`else
  logic [31:0] unused_div_num;
  assign unused_div_num = 32'(DIV_NUM);
`endif

  // Synchronizer shift, edge detection and the free-running saturating counter
  always_comb begin
    sync_d = {sync_q[1:0], sig_in};
    rise_c = sync_q[1] & ~sync_q[2];
    fall_c = ~sync_q[1] & sync_q[2];
    sat_c  = (cnt_q == CNT_MAX);
    if (rise_c) begin
      cnt_d = CNT_W'(1);
    end else if (sat_c) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Measurement FSM: next state, captures, lock tracking and timeout handling
  always_comb begin
    state_d       = state_q;
    hi_cap_d      = hi_cap_q;
    period_d      = period_q;
    high_time_d   = high_time_q;
    meas_valid_d  = 1'b0;
    locked_d      = locked_q;
    err_timeout_d = err_timeout_q;
    lock_cnt_d    = lock_cnt_q;
    publish_c     = 1'b0;
    timeout_c     = 1'b0;
`ifdef EXPECT_CHECK_EN
    period_ok_d   = period_ok_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (rise_c) state_d = S_HIGH;
      end
      S_HIGH: begin
        // A rise without a fall is handled as if the cycle were in LOW
        if (rise_c) begin
          publish_c = 1'b1;
        end else if (sat_c) begin
          timeout_c = 1'b1;
        end else if (fall_c) begin
          hi_cap_d = cnt_q;
          state_d  = S_LOW;
        end
      end
      S_LOW: begin
        // A rise wins over saturation in the same cycle
        if (rise_c) begin
          publish_c = 1'b1;
        end else if (sat_c) begin
          timeout_c = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (publish_c) begin
      state_d       = S_HIGH;
      period_d      = cnt_q;
      high_time_d   = hi_cap_q;
      meas_valid_d  = 1'b1;
      err_timeout_d = 1'b0;
      if (lock_cnt_q == '0) begin
        lock_cnt_d = LCK_W'(1);
      end else if (cnt_q == period_q) begin
        lock_cnt_d = (lock_cnt_q == LOCK_TGT) ? lock_cnt_q : lock_cnt_q + LCK_W'(1);
      end else begin
        lock_cnt_d = LCK_W'(1);
      end
      locked_d = (lock_cnt_d == LOCK_TGT);
`ifdef EXPECT_CHECK_EN
      period_ok_d = (cnt_q == CNT_W'(DIV_NUM)) &&
                    ({hi_cap_q, 1'b0} == {1'b0, cnt_q});
`endif
    end else if (timeout_c) begin
      state_d       = S_IDLE;
      err_timeout_d = 1'b1;
      locked_d      = 1'b0;
      lock_cnt_d    = '0;
`ifdef EXPECT_CHECK_EN
      period_ok_d   = 1'b0;
`endif
    end
  end

  // State and datapath registers
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      sync_q        <= '0;
      cnt_q         <= '0;
      hi_cap_q      <= '0;
      period_q      <= '0;
      high_time_q   <= '0;
      meas_valid_q  <= 1'b0;
      locked_q      <= 1'b0;
      err_timeout_q <= 1'b0;
      lock_cnt_q    <= '0;
      state_q       <= S_IDLE;
`ifdef EXPECT_CHECK_EN
      period_ok_q   <= 1'b0;
`endif
    end else begin
      sync_q        <= sync_d;
      cnt_q         <= cnt_d;
      hi_cap_q      <= hi_cap_d;
      period_q      <= period_d;
      high_time_q   <= high_time_d;
      meas_valid_q  <= meas_valid_d;
      locked_q      <= locked_d;
      err_timeout_q <= err_timeout_d;
      lock_cnt_q    <= lock_cnt_d;
      state_q       <= state_d;
`ifdef EXPECT_CHECK_EN
      period_ok_q   <= period_ok_d;
`endif
    end
  end

  assign period      = period_q;
  assign high_time   = high_time_q;
  assign meas_valid  = meas_valid_q;
  assign locked      = locked_q;
  assign err_timeout = err_timeout_q;
`ifdef EXPECT_CHECK_EN
  assign period_ok   = period_ok_q;
`endif

endmodule

// File: doc/div_clk_meter.md
Name: div_clk_meter

Overview:
- Measures a divided clock such as the output of the even clock divider.
- Counts `clk_in` cycles to report the period and high time of `sig_in`.
- Flags loss of signal and asserts a lock indicator once the period is stable.
- Used in bring-up and self-test to confirm that divider outputs match their configured divide ratio.

Parameters:
- CNT_W, 16, width of the period and high-time counters; the saturation value is 2^CNT_W-1.
- LOCK_NUM, 4, number of consecutive equal periods required to assert `locked`.
- DIV_NUM, 8, expected divide ratio; used only when `EXPECT_CHECK_EN` is defined.

Ports:
- clk_in  input  1  measurement clock; the divider's source clock.
- rst  input  1  asynchronous, active-high reset.
- sig_in  input  1  divided clock under measurement; treated as asynchronous.
- period  output  CNT_W  last measured period, in `clk_in` cycles.
- high_time  output  CNT_W  last measured high time, in `clk_in` cycles.
- meas_valid  output  1  one-cycle pulse when `period` and `high_time` update.
- locked  output  1  period stable for LOCK_NUM consecutive measurements.
- err_timeout  output  1  sticky flag: no rising edge seen within 2^CNT_W-1 cycles.
- period_ok  output  1  only with `EXPECT_CHECK_EN`: last period equals DIV_NUM and the duty cycle is 50%.

Behaviour:
- Reset: one clock (`clk_in`); reset `rst` is asynchronous and active-high. While `rst` is high, all outputs are 0, all counters are 0, the synchronizer is 0 and the FSM is in IDLE.
- Input path:
  - `sig_in` passes through a 2-flop synchronizer, then a third flop used for edge detection.
  - rise = s2 & ~s3; fall = ~s2 & s3.
  - Fixed latency: 3 `clk_in` cycles from `sig_in` being sampled high to `meas_valid`.
- Counter `cnt`:
  - Set to 1 on a rise cycle; otherwise increments each cycle.
  - Saturates at 2^CNT_W-1 and never wraps.
- Latch `hi_cap`: captures `cnt` on a fall cycle.
- FSM states and transitions:
  - IDLE: wait for a rise, then go to HIGH. No output update on this first rise.
  - HIGH: on fall, capture `hi_cap` and go to LOW. On a rise without a fall (not possible after sync), treat as LOW.
  - LOW: on rise, register `period` <= `cnt` and `high_time` <= `hi_cap`, pulse `meas_valid` for 1 cycle, clear `err_timeout`, then go to HIGH.
  - Any state except IDLE: if `cnt` reaches saturation, set `err_timeout`, clear `locked` and the lock counter, and go to IDLE. `period` and `high_time` keep their last values.
- Example: an 8:1 even-divided input gives period=8 and high_time=4. The fastest input (toggling every cycle) gives period=2 and high_time=1.
- Lock counter (width covers LOCK_NUM), evaluated on each `meas_valid`:
  - If the new period equals the previous registered period, increment; the counter saturates at LOCK_NUM.
  - Otherwise reset the counter to 1 and clear `locked`.
  - `locked` = (counter == LOCK_NUM); it updates in the same cycle as `meas_valid`.
  - The first measurement after IDLE sets the counter to 1.
- Simultaneous events: a rise in LOW takes priority over saturation in the same cycle; the measurement is published and `err_timeout` stays clear.
- Reset mid-measurement: everything returns to IDLE immediately. The first `meas_valid` after reset needs two full rises.

Optional Feature:
- Macro: `EXPECT_CHECK_EN`.
- Defined:
  - Port `period_ok` exists.
  - On each `meas_valid`, `period_ok` <= (`period` == DIV_NUM) && (2*`high_time` == `period`).
  - `period_ok` is cleared by reset and by timeout, and holds between measurements.
- Undefined: the port and its logic are absent, and DIV_NUM is unused.

Test Plan:
- 8:1 even divider output (4 high / 4 low) after reset -> first `meas_valid` on the 2nd rise; period=8, high_time=4; `locked`=1 at the 4th `meas_valid`; `period_ok`=1.
- `sig_in` toggling every `clk_in` cycle -> period=2, high_time=1 on every `meas_valid`; no timeout.
- 12-cycle period, then switch to 10 -> first 10-cycle measurement clears `locked`; `locked` reasserts after 4 consecutive 10-cycle measurements.
- CNT_W=6 with `sig_in` stuck low after a lock -> `err_timeout`=1 once `cnt` reaches 63; `locked`=0; period keeps its last value; resuming toggling clears `err_timeout` on the next `meas_valid`.
- `rst` pulsed high mid-LOW -> all outputs 0 immediately; the next `meas_valid` occurs only after two rises.
- `EXPECT_CHECK_EN` with DIV_NUM=8 and a 3-high / 5-low input -> period=8, high_time=3, `period_ok`=0.
